// File: rtl/alu_issue_stage_pkg.sv
// Shared encodings for the ALU issue stage, the ALU and main control.
//   - ALU select values driven onto the ALU select input
//   - main-control ALUOp encodings
//   - R-type opcode field values (instruction[31:21])
//   - XZR register index (reads as zero, writes discarded)
package alu_issue_stage_pkg;

  localparam logic [3:0] SEL_AND = 4'b0000;
  localparam logic [3:0] SEL_EOR = 4'b0001;
  localparam logic [3:0] SEL_ADD = 4'b0010;
  localparam logic [3:0] SEL_SUB = 4'b0110;

  typedef enum logic [1:0] {
    ALUOP_MEM   = 2'b00,  // load/store address add
    ALUOP_CMP   = 2'b01,  // pass-B / compare (subtract)
    ALUOP_RTYPE = 2'b10,  // decode from opcode field
    ALUOP_RSVD  = 2'b11
  } aluop_e;

  localparam logic [10:0] OPC_ADD = 11'b10001011000;
  localparam logic [10:0] OPC_SUB = 11'b11001011000;
  localparam logic [10:0] OPC_AND = 11'b10001010000;
  localparam logic [10:0] OPC_EOR = 11'b11001010000;

  localparam logic [4:0] XZR = 5'd31;

endpackage

// File: rtl/alu_select_decode.sv
// Combinational ALU select decode.
//   aluop   : main-control ALUOp
//   opcode  : R-type opcode field
//   select  : ALU select
//   illegal : unsupported ALUOp/opcode combination (select falls back to ADD)
module alu_select_decode
  import alu_issue_stage_pkg::*;
#(
  parameter int SEL_WIDTH = 4,
  parameter int OPC_WIDTH = 11
) (
  input  logic [1:0]           aluop,
  input  logic [OPC_WIDTH-1:0] opcode,
  output logic [SEL_WIDTH-1:0] select,
  output logic                 illegal
);

  always_comb begin
    select  = SEL_WIDTH'(SEL_ADD);
    illegal = 1'b0;
    case (aluop)
      ALUOP_MEM: select = SEL_WIDTH'(SEL_ADD);
      ALUOP_CMP: select = SEL_WIDTH'(SEL_SUB);
      ALUOP_RTYPE: begin
        if      (opcode == OPC_WIDTH'(OPC_ADD)) select = SEL_WIDTH'(SEL_ADD);
        else if (opcode == OPC_WIDTH'(OPC_SUB)) select = SEL_WIDTH'(SEL_SUB);
        else if (opcode == OPC_WIDTH'(OPC_AND)) select = SEL_WIDTH'(SEL_AND);
        else if (opcode == OPC_WIDTH'(OPC_EOR)) select = SEL_WIDTH'(SEL_EOR);
        else                                    illegal = 1'b1;
      end
      default: illegal = 1'b1;  // reserved ALUOp
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX stage feeding the 64-bit ALU.
//   in_*      : decoded instruction from ID, valid/ready handshake
//   flush     : drop the held instruction and the incoming one
//   out_*     : ALU select, forwarded operands A/B, destination, illegal flag
//   exm_*     : EX/MEM bypass (write enable, dest, data)
//   mwb_*     : MEM/WB bypass (write enable, dest, data)
// Control and operands are registered on load; forwarding is applied
// combinationally on the outputs so a bypass arriving while the stage is
// stalled still reaches the ALU.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int SEL_WIDTH  = 4,
  parameter int REG_AW     = 5,
  parameter int OPC_WIDTH  = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_aluop,
  input  logic [OPC_WIDTH-1:0]  in_opcode,
  input  logic                  in_use_imm,
  input  logic [DATA_WIDTH-1:0] in_imm,
  input  logic [REG_AW-1:0]     in_rn,
  input  logic [REG_AW-1:0]     in_rm,
  input  logic [REG_AW-1:0]     in_rd,
  input  logic [DATA_WIDTH-1:0] in_rdata1,
  input  logic [DATA_WIDTH-1:0] in_rdata2,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SEL_WIDTH-1:0]  out_select,
  output logic [DATA_WIDTH-1:0] out_a,
  output logic [DATA_WIDTH-1:0] out_b,
  output logic [REG_AW-1:0]     out_rd,
  output logic                  out_illegal,
  input  logic                  exm_wen,
  input  logic [REG_AW-1:0]     exm_rd,
  input  logic [DATA_WIDTH-1:0] exm_data,
  input  logic                  mwb_wen,
  input  logic [REG_AW-1:0]     mwb_rd,
  input  logic [DATA_WIDTH-1:0] mwb_data
);

  logic [SEL_WIDTH-1:0] dec_sel;
  logic                 dec_ill;

  alu_select_decode #(.SEL_WIDTH(SEL_WIDTH), .OPC_WIDTH(OPC_WIDTH)) u_dec (
    .aluop   (in_aluop),
    .opcode  (in_opcode),
    .select  (dec_sel),
    .illegal (dec_ill)
  );

  logic                  vld_q,     vld_d;
  logic [SEL_WIDTH-1:0]  sel_q,     sel_d;
  logic                  ill_q,     ill_d;
  logic [REG_AW-1:0]     rn_q,      rn_d;
  logic [REG_AW-1:0]     rm_q,      rm_d;
  logic [REG_AW-1:0]     rd_q,      rd_d;
  logic                  use_imm_q, use_imm_d;
  logic [DATA_WIDTH-1:0] imm_q,     imm_d;
  logic [DATA_WIDTH-1:0] rdata1_q,  rdata1_d;
  logic [DATA_WIDTH-1:0] rdata2_q,  rdata2_d;

  logic load;

  assign in_ready = !vld_q | out_ready;
  assign load     = in_valid & in_ready & !flush;

  always_comb begin
    vld_d     = vld_q;
    sel_d     = sel_q;
    ill_d     = ill_q;
    rn_d      = rn_q;
    rm_d      = rm_q;
    rd_d      = rd_q;
    use_imm_d = use_imm_q;
    imm_d     = imm_q;
    rdata1_d  = rdata1_q;
    rdata2_d  = rdata2_q;
    if (flush) begin
      // Fields are left untouched: a flushed instruction is never captured.
      vld_d = 1'b0;
    end else if (load) begin
      vld_d     = 1'b1;
      sel_d     = dec_sel;
      ill_d     = dec_ill;
      rn_d      = in_rn;
      rm_d      = in_rm;
      rd_d      = in_rd;
      use_imm_d = in_use_imm;
      imm_d     = in_imm;
      rdata1_d  = in_rdata1;
      rdata2_d  = in_rdata2;
    end else if (out_ready) begin
      vld_d = 1'b0;  // drained with nothing behind it
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q     <= 1'b0;
      sel_q     <= '0;
      ill_q     <= 1'b0;
      rn_q      <= '0;
      rm_q      <= '0;
      rd_q      <= '0;
      use_imm_q <= 1'b0;
      imm_q     <= '0;
      rdata1_q  <= '0;
      rdata2_q  <= '0;
    end else begin
      vld_q     <= vld_d;
      sel_q     <= sel_d;
      ill_q     <= ill_d;
      rn_q      <= rn_d;
      rm_q      <= rm_d;
      rd_q      <= rd_d;
      use_imm_q <= use_imm_d;
      imm_q     <= imm_d;
      rdata1_q  <= rdata1_d;
      rdata2_q  <= rdata2_d;
    end
  end

  // XZR check first means a bypass targeting X31 can never match.
  function automatic logic [DATA_WIDTH-1:0] fwd(
    input logic [REG_AW-1:0]     src,
    input logic [DATA_WIDTH-1:0] rf_data,
    input logic                  e_wen,
    input logic [REG_AW-1:0]     e_rd,
    input logic [DATA_WIDTH-1:0] e_data,
    input logic                  m_wen,
    input logic [REG_AW-1:0]     m_rd,
    input logic [DATA_WIDTH-1:0] m_data
  );
    if (src == REG_AW'(XZR))       return '0;
    else if (e_wen && e_rd == src) return e_data;
    else if (m_wen && m_rd == src) return m_data;
    else                           return rf_data;
  endfunction

  assign out_a = fwd(rn_q, rdata1_q, exm_wen, exm_rd, exm_data,
                     mwb_wen, mwb_rd, mwb_data);
  assign out_b = use_imm_q ? imm_q
               : fwd(rm_q, rdata2_q, exm_wen, exm_rd, exm_data,
                     mwb_wen, mwb_rd, mwb_data);

  assign out_valid   = vld_q;
  assign out_select  = sel_q;
  assign out_rd      = rd_q;
  assign out_illegal = ill_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [1:0]  in_aluop;
  logic [10:0] in_opcode;
  logic        in_use_imm;
  logic [63:0] in_imm;
  logic [4:0]  in_rn, in_rm, in_rd;
  logic [63:0] in_rdata1, in_rdata2;
  logic        flush;
  logic        out_valid, out_ready;
  logic [3:0]  out_select;
  logic [63:0] out_a, out_b;
  logic [4:0]  out_rd;
  logic        out_illegal;
  logic        exm_wen, mwb_wen;
  logic [4:0]  exm_rd, mwb_rd;
  logic [63:0] exm_data, mwb_data;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_aluop(in_aluop), .in_opcode(in_opcode),
    .in_use_imm(in_use_imm), .in_imm(in_imm),
    .in_rn(in_rn), .in_rm(in_rm), .in_rd(in_rd),
    .in_rdata1(in_rdata1), .in_rdata2(in_rdata2),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_select(out_select), .out_a(out_a), .out_b(out_b),
    .out_rd(out_rd), .out_illegal(out_illegal),
    .exm_wen(exm_wen), .exm_rd(exm_rd), .exm_data(exm_data),
    .mwb_wen(mwb_wen), .mwb_rd(mwb_rd), .mwb_data(mwb_data)
  );

  typedef struct {
    logic [1:0]  aluop;
    logic [10:0] opc;
    logic        use_imm;
    logic [63:0] imm;
    logic [4:0]  rn, rm, rd;
    logic [63:0] rd1, rd2;
    logic        ew;
    logic [4:0]  erd;
    logic [63:0] ed;
    logic        mw;
    logic [4:0]  mrd;
    logic [63:0] md;
    logic [3:0]  e_sel;
    logic        e_ill;
    logic [63:0] e_a, e_b;
  } vec_t;

  localparam logic [10:0] O_ADD = 11'b10001011000;
  localparam logic [10:0] O_SUB = 11'b11001011000;
  localparam logic [10:0] O_AND = 11'b10001010000;
  localparam logic [10:0] O_EOR = 11'b11001010000;
  localparam logic [10:0] O_BAD = 11'b11111111111;
  localparam logic [63:0] IMM_N8 = 64'hFFFF_FFFF_FFFF_FFF8;

  int tests = 0;
  int fails = 0;
  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_instr(input logic [1:0] aluop, input logic [10:0] opc,
                             input logic ui, input logic [63:0] imm,
                             input logic [4:0] rn, input logic [4:0] rm, input logic [4:0] rd,
                             input logic [63:0] d1, input logic [63:0] d2);
    in_aluop = aluop; in_opcode = opc; in_use_imm = ui; in_imm = imm;
    in_rn = rn; in_rm = rm; in_rd = rd; in_rdata1 = d1; in_rdata2 = d2;
  endtask

  initial begin
    //          aluop opc    ui imm     rn  rm  rd  rd1    rd2    ew erd ed     mw mrd md     sel   ill a      b
    vecs[0]  = '{2'b10, O_ADD, 0, 64'h0, 1,  2,  3,  64'h5, 64'h7, 0, 0,  64'h0,  0, 0,  64'h0,  4'b0010, 0, 64'h5,  64'h7};
    vecs[1]  = '{2'b10, O_ADD, 0, 64'h0, 3,  2,  4,  64'h11,64'h22,1, 3,  64'hAA, 1, 3,  64'hBB, 4'b0010, 0, 64'hAA, 64'h22};
    vecs[2]  = '{2'b10, O_ADD, 0, 64'h0, 3,  2,  4,  64'h11,64'h22,0, 3,  64'hAA, 1, 3,  64'hBB, 4'b0010, 0, 64'hBB, 64'h22};
    vecs[3]  = '{2'b10, O_ADD, 0, 64'h0, 31, 2,  5,  64'h11,64'h22,1, 31, 64'hAA, 1, 31, 64'hBB, 4'b0010, 0, 64'h0,  64'h22};
    vecs[4]  = '{2'b00, 11'h0, 1, IMM_N8,6,  4,  6,  64'h33,64'h44,1, 4,  64'hCC, 0, 0,  64'h0,  4'b0010, 0, 64'h33, IMM_N8};
    vecs[5]  = '{2'b10, O_SUB, 0, 64'h0, 8,  5,  7,  64'h1, 64'h2, 0, 0,  64'h0,  1, 5,  64'h55, 4'b0110, 0, 64'h1,  64'h55};
    vecs[6]  = '{2'b10, O_AND, 0, 64'h0, 9,  10, 1,  64'h3, 64'h4, 1, 10, 64'h66, 1, 10, 64'h77, 4'b0000, 0, 64'h3,  64'h66};
    vecs[7]  = '{2'b10, O_EOR, 0, 64'h0, 31, 31, 2,  64'h8, 64'h9, 1, 31, 64'hEE, 1, 31, 64'hFF, 4'b0001, 0, 64'h0,  64'h0};
    vecs[8]  = '{2'b01, O_BAD, 0, 64'h0, 2,  3,  8,  64'h9, 64'hA, 0, 0,  64'h0,  0, 0,  64'h0,  4'b0110, 0, 64'h9,  64'hA};
    vecs[9]  = '{2'b10, O_BAD, 0, 64'h0, 2,  3,  9,  64'hB, 64'hC, 0, 0,  64'h0,  0, 0,  64'h0,  4'b0010, 1, 64'hB,  64'hC};
    vecs[10] = '{2'b11, O_ADD, 0, 64'h0, 2,  3,  10, 64'hD, 64'hE, 0, 0,  64'h0,  0, 0,  64'h0,  4'b0010, 1, 64'hD,  64'hE};
    vecs[11] = '{2'b10, O_ADD, 0, 64'h0, 12, 12, 11, 64'h1, 64'h2, 0, 12, 64'h99, 1, 12, 64'h123,4'b0010, 0, 64'h123,64'h123};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    drive_instr(2'b00, 11'h0, 1'b0, 64'h0, 5'd0, 5'd0, 5'd0, 64'h0, 64'h0);
    exm_wen = 1'b0; exm_rd = 5'd0; exm_data = 64'h0;
    mwb_wen = 1'b0; mwb_rd = 5'd0; mwb_data = 64'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid",   {63'd0, out_valid},   64'd0);
    chk("rst_select",  {60'd0, out_select},  64'd0);
    chk("rst_rd",      {59'd0, out_rd},      64'd0);
    chk("rst_illegal", {63'd0, out_illegal}, 64'd0);
    chk("rst_a",       out_a,                64'd0);
    chk("rst_b",       out_b,                64'd0);
    chk("rst_in_ready",{63'd0, in_ready},    64'd1);
    @(negedge clk); rst = 1'b0;

    // Back-to-back vectors: one load per cycle, checked after the load edge.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive_instr(vecs[i].aluop, vecs[i].opc, vecs[i].use_imm, vecs[i].imm,
                  vecs[i].rn, vecs[i].rm, vecs[i].rd, vecs[i].rd1, vecs[i].rd2);
      exm_wen = vecs[i].ew; exm_rd = vecs[i].erd; exm_data = vecs[i].ed;
      mwb_wen = vecs[i].mw; mwb_rd = vecs[i].mrd; mwb_data = vecs[i].md;
      in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid", i),   {63'd0, out_valid},   64'd1);
      chk($sformatf("v%0d_select", i),  {60'd0, out_select},  {60'd0, vecs[i].e_sel});
      chk($sformatf("v%0d_illegal", i), {63'd0, out_illegal}, {63'd0, vecs[i].e_ill});
      chk($sformatf("v%0d_rd", i),      {59'd0, out_rd},      {59'd0, vecs[i].rd});
      chk($sformatf("v%0d_a", i),       out_a,                vecs[i].e_a);
      chk($sformatf("v%0d_b", i),       out_b,                vecs[i].e_b);
    end

    // Forwarding follows live bypass inputs while the instruction is held.
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b1;
    drive_instr(2'b10, O_ADD, 1'b0, 64'h0, 5'd3, 5'd4, 5'd20, 64'h11, 64'h22);
    exm_wen = 1'b0; mwb_wen = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    exm_wen = 1'b1; exm_rd = 5'd3; exm_data = 64'hAA;
    mwb_wen = 1'b1; mwb_rd = 5'd3; mwb_data = 64'hBB;
    #1 chk("live_fwd_exm", out_a, 64'hAA);
    exm_wen = 1'b0;
    #1 chk("live_fwd_mwb", out_a, 64'hBB);
    mwb_wen = 1'b0;
    #1 chk("live_fwd_none", out_a, 64'h11);

    // Backpressure: A held for 3 cycles, B waits, then B follows exactly once.
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1;
    drive_instr(2'b00, 11'h0, 1'b0, 64'h0, 5'd1, 5'd2, 5'd10, 64'h100, 64'h101);
    @(negedge clk);
    drive_instr(2'b01, 11'h0, 1'b0, 64'h0, 5'd1, 5'd2, 5'd11, 64'h200, 64'h201);
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1 chk($sformatf("bp%0d_in_ready", c), {63'd0, in_ready}, 64'd0);
      @(posedge clk); #1;
      chk($sformatf("bp%0d_valid", c), {63'd0, out_valid}, 64'd1);
      chk($sformatf("bp%0d_rd", c),    {59'd0, out_rd},    64'd10);
      chk($sformatf("bp%0d_a", c),     out_a,              64'h100);
      chk($sformatf("bp%0d_sel", c),   {60'd0, out_select}, 64'h2);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1 chk("bp_release_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    chk("bp_next_valid", {63'd0, out_valid},  64'd1);
    chk("bp_next_rd",    {59'd0, out_rd},     64'd11);
    chk("bp_next_a",     out_a,               64'h200);
    chk("bp_next_sel",   {60'd0, out_select}, 64'h6);
    @(negedge clk); in_valid = 1'b0;
    @(posedge clk); #1;
    chk("bp_drain_valid", {63'd0, out_valid}, 64'd0);

    // Flush with an accepted-looking input: nothing captured.
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b1; flush = 1'b1;
    drive_instr(2'b10, O_SUB, 1'b0, 64'h0, 5'd5, 5'd6, 5'd12, 64'h300, 64'h301);
    #1 chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    chk("flush_valid",  {63'd0, out_valid},  64'd0);
    chk("flush_rd",     {59'd0, out_rd},     64'd11);
    chk("flush_select", {60'd0, out_select}, 64'h6);

    // Flush overrides hold.
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b1;
    @(posedge clk); #1;
    chk("flush_hold_valid", {63'd0, out_valid}, 64'd0);

    // Reset while stalled.
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    drive_instr(2'b10, O_EOR, 1'b0, 64'h0, 5'd1, 5'd2, 5'd13, 64'h400, 64'h401);
    @(posedge clk); #1;
    chk("prerst_valid", {63'd0, out_valid}, 64'd1);
    @(negedge clk);
    out_ready = 1'b0; rst = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    chk("midrst_valid",    {63'd0, out_valid},  64'd0);
    chk("midrst_select",   {60'd0, out_select}, 64'd0);
    chk("midrst_rd",       {59'd0, out_rd},     64'd0);
    chk("midrst_in_ready", {63'd0, in_ready},   64'd1);
    @(negedge clk);
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID/EX pipeline stage directly upstream of the 64-bit ALU.
- Decodes the ALU select from main-control ALUOp plus the R-type opcode field.
- Registers operands and control under a valid/ready handshake.
- Applies EX/MEM and MEM/WB forwarding on the operand outputs that drive ALU inputs A and B.

Parameters:
- DATA_WIDTH, 64, operand/immediate width.
- SEL_WIDTH, 4, ALU select width.
- REG_AW, 5, register index width (X0..X31, X31 = XZR).
- OPC_WIDTH, 11, R-type opcode field width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  decode stage presents an instruction.
- in_ready  out  1  stage can accept this cycle.
- in_aluop  in  2  00 = add (load/store), 01 = pass-B/compare, 10 = R-type, 11 = reserved.
- in_opcode  in  OPC_WIDTH  instruction[31:21].
- in_use_imm  in  1  1 = operand B from in_imm.
- in_imm  in  DATA_WIDTH  sign-extended immediate.
- in_rn, in_rm, in_rd  in  REG_AW each  source/destination indices.
- in_rdata1, in_rdata2  in  DATA_WIDTH each  register-file read data.
- flush  in  1  kill the held instruction and the incoming one.
- out_valid  out  1  ALU inputs valid.
- out_ready  in  1  EX stage consumes this cycle.
- out_select  out  SEL_WIDTH  ALU select.
- out_a, out_b  out  DATA_WIDTH each  forwarded operands.
- out_rd  out  REG_AW  registered destination.
- out_illegal  out  1  unsupported ALUOp/opcode.
- exm_wen, exm_rd, exm_data  in  1/REG_AW/DATA_WIDTH  EX/MEM bypass.
- mwb_wen, mwb_rd, mwb_data  in  1/REG_AW/DATA_WIDTH  MEM/WB bypass.

Behaviour:
- Reset: all stage registers cleared; out_valid = 0, out_select = 0000, out_rd = 0, out_illegal = 0, out_a = out_b = 0 (unless bypass hits, see forwarding).
- Handshake:
  - in_ready = !out_valid | out_ready (combinational).
  - Load when in_valid & in_ready & !flush. The loaded instruction appears the next cycle: 1-cycle latency, full throughput.
  - out_valid & !out_ready: hold all registers; in_ready = 0.
  - Transfer-out without a new load: out_valid <= 0.
- Flush: out_valid <= 0 next cycle; overrides load and hold. in_ready stays per the formula, but nothing is captured.
- ALU select decode (registered at load):
  - aluop 00 -> 0010 (add).
  - aluop 01 -> 0110 (sub, for compare/branch zero test).
  - aluop 10, opcode 10001011000 (ADD) -> 0010.
  - aluop 10, opcode 11001011000 (SUB) -> 0110.
  - aluop 10, opcode 10001010000 (AND) -> 0000.
  - aluop 10, opcode 11001010000 (EOR) -> 0001.
  - Any other combination: select 0010, illegal = 1; the instruction is still passed, and the downstream stage traps.
- Registered fields: select, illegal, rn, rm, rd, use_imm, imm, rdata1, rdata2.
- Forwarding (combinational on registered fields plus current bypass inputs):
  - out_a: if rn == 31 -> 0; else if exm_wen & exm_rd == rn -> exm_data; else if mwb_wen & mwb_rd == rn -> mwb_data; else rdata1.
  - out_b: if use_imm -> imm, with no forwarding. Otherwise apply the same chain to rm and rdata2.
  - EX/MEM beats MEM/WB. A bypass with rd == 31 never forwards.
- Width: no arithmetic here. Immediate passes unmodified; sign extension is upstream.
- Reset mid-operation: the held instruction is dropped and out_valid = 0 the following cycle. rst beats flush and load.

Decomposition:
- Shared package: ALU select constants (SEL_AND 0000, SEL_EOR 0001, SEL_ADD 0010, SEL_SUB 0110), ALUOp encodings, R-type opcode constants, XZR index 31.
- These constants are shared with the ALU and main control.
- One sub-module: alu_select_decode (combinational aluop/opcode -> select, illegal). The stage registers and forwarding stay in the top.

Test Plan:
- R-type ADD: aluop 10, opcode 10001011000, rn = 1, rm = 2, rdata1 = 5, rdata2 = 7, no bypass -> next cycle out_valid = 1, select 0010, out_a = 5, out_b = 7.
- Forwarding priority: rn = 3, exm_wen = 1, exm_rd = 3, exm_data = 0xAA, mwb_wen = 1, mwb_rd = 3, mwb_data = 0xBB -> out_a = 0xAA. Drop exm_wen -> out_a = 0xBB. Set rn = 31 -> out_a = 0 regardless.
- Immediate: in_use_imm = 1, in_imm = 0xFFFF_FFFF_FFFF_FFF8, rm bypass hit -> out_b = 0xFFFF_FFFF_FFFF_FFF8, aluop 00 -> select 0010.
- Backpressure: out_ready = 0 for 3 cycles with in_valid = 1 -> in_ready = 0, outputs stable. Raise out_ready -> the next instruction appears 1 cycle later with no loss or duplication.
- Flush with in_valid = 1 and in_ready = 1 -> next cycle out_valid = 0 and no capture. Illegal opcode 11111111111 with aluop 10 -> out_illegal = 1, select 0010.
- Assert rst while out_valid = 1 and out_ready = 0 -> next cycle out_valid = 0, out_select = 0000, in_ready = 1.
